accum_table: RTL and testbench

ACCUM_TABLE -- requirements
Module: accum_table

---
 rtl/accum_table_if.sv | 25 ++
 rtl/accum_table.sv | 101 ++++++++++
 tb/tb_accum_table.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/accum_table_if.sv
// Write/read bus of the accumulator table. The master drives per-column writes and
// broadside row reads; the slave returns the row.
interface accum_table_if #(
    parameter int SYS_ARR_COLS = 16,
    parameter int ADDR_W       = 10,
    parameter int ACC_WIDTH    = 32
);
    logic [SYS_ARR_COLS-1:0]           wr_en;
    logic [ADDR_W*SYS_ARR_COLS-1:0]    wr_addr;
    logic [SYS_ARR_COLS-1:0]           wr_overwrite;
    logic [ACC_WIDTH*SYS_ARR_COLS-1:0] wr_data;
    logic                              rd_en;
    logic [ADDR_W-1:0]                 rd_addr;
    logic [ACC_WIDTH*SYS_ARR_COLS-1:0] rd_data;
    logic                              rd_valid;

    modport master (
        output wr_en, wr_addr, wr_overwrite, wr_data, rd_en, rd_addr,
        input  rd_data, rd_valid
    );
    modport slave (
        input  wr_en, wr_addr, wr_overwrite, wr_data, rd_en, rd_addr,
        output rd_data, rd_valid
    );
endinterface

// File: rtl/accum_table.sv
// Banked partial-sum accumulator for a systolic array: one bank per array column,
// each with a two-stage read-modify-write pipeline and a registered broadside read.
module accum_bank #(
    parameter int DEPTH     = 1024,
    parameter int ADDR_W    = 10,
    parameter int ACC_WIDTH = 32
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_wr_en,
    input  logic [ADDR_W-1:0]    i_wr_addr,
    input  logic                 i_wr_ov,
    input  logic [ACC_WIDTH-1:0] i_wr_data,
    input  logic                 i_rd_en,
    input  logic [ADDR_W-1:0]    i_rd_addr,
    output logic [ACC_WIDTH-1:0] o_rd_word
);
    logic [ACC_WIDTH-1:0] r_mem [DEPTH];
    logic                 r_s1_vld;
    logic [ADDR_W-1:0]    r_s1_addr;
    logic                 r_s1_ov;
    logic [ACC_WIDTH-1:0] r_s1_data;
    logic [ACC_WIDTH-1:0] r_s1_word;
    logic [ACC_WIDTH-1:0] w_result;
    logic                 w_fwd;

    assign w_result = r_s1_ov ? r_s1_data : (r_s1_word + r_s1_data);
    // The bank still holds the old word while stage 2 commits, so a back-to-back
    // hit on the same row must take the stage-2 result instead.
    assign w_fwd    = r_s1_vld && (r_s1_addr == i_wr_addr);

    always_ff @(posedge i_clk) begin
        if (i_reset) r_s1_vld <= 1'b0;
        else         r_s1_vld <= i_wr_en;
    end

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_s1_addr <= i_wr_addr;
            r_s1_ov   <= i_wr_ov;
            r_s1_data <= i_wr_data;
            r_s1_word <= w_fwd ? w_result : r_mem[i_wr_addr];
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset && r_s1_vld) r_mem[r_s1_addr] <= w_result;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset)      o_rd_word <= '0;
        else if (i_rd_en) o_rd_word <= r_mem[i_rd_addr];
    end
endmodule

module accum_table #(
    parameter int DATA_WIDTH   = 8,
    parameter int MAX_OUT_ROWS = 128,
    parameter int MAX_OUT_COLS = 128,
    parameter int SYS_ARR_COLS = 16,
    parameter int ACC_WIDTH    = 32,
    localparam int NUM_ACCUM_ROWS = MAX_OUT_ROWS * (MAX_OUT_COLS / SYS_ARR_COLS),
    localparam int ADDR_W         = $clog2(NUM_ACCUM_ROWS)
) (
    input logic         clk,
    input logic         reset,
    accum_table_if.slave bus
);
    logic [SYS_ARR_COLS-1:0][ACC_WIDTH-1:0] w_rd_data;
    logic                                   r_rd_valid;

    if (DATA_WIDTH < 1 || NUM_ACCUM_ROWS < 2) begin : g_bad_cfg
        $error("accum_table: invalid parameter set");
    end

    for (genvar c = 0; c < SYS_ARR_COLS; c++) begin : g_col
        accum_bank #(
            .DEPTH     (NUM_ACCUM_ROWS),
            .ADDR_W    (ADDR_W),
            .ACC_WIDTH (ACC_WIDTH)
        ) u_bank (
            .i_clk     (clk),
            .i_reset   (reset),
            .i_wr_en   (bus.wr_en[c]),
            .i_wr_addr (bus.wr_addr[c*ADDR_W +: ADDR_W]),
            .i_wr_ov   (bus.wr_overwrite[c]),
            .i_wr_data (bus.wr_data[c*ACC_WIDTH +: ACC_WIDTH]),
            .i_rd_en   (bus.rd_en),
            .i_rd_addr (bus.rd_addr),
            .o_rd_word (w_rd_data[c])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) r_rd_valid <= 1'b0;
        else       r_rd_valid <= bus.rd_en;
    end

    assign bus.rd_data  = w_rd_data;
    assign bus.rd_valid = r_rd_valid;
endmodule

// File: tb/tb_accum_table.sv
// Scenario bench for accum_table: expected row words are queued when a read is
// issued and popped against rd_data once the read returns.
module tb_accum_table;
    localparam int COLS = 16;
    localparam int AW   = 10;
    localparam int AC   = 32;

    typedef struct {
        int          col;
        logic [31:0] val;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    accum_table_if #(.SYS_ARR_COLS(COLS), .ADDR_W(AW), .ACC_WIDTH(AC)) bus ();

    accum_table dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wr_en = '0;
        bus.rd_en = 1'b0;
    endtask

    task automatic wr(input int col, input int addr, input bit ov, input logic [31:0] d);
        logic [AW-1:0] a;
        a = addr[AW-1:0];
        bus.wr_en[col]                = 1'b1;
        bus.wr_addr[col*AW +: AW]     = a;
        bus.wr_overwrite[col]         = ov;
        bus.wr_data[col*AC +: AC]     = d;
    endtask

    task automatic rd(input int addr);
        bus.rd_en   = 1'b1;
        bus.rd_addr = addr[AW-1:0];
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        rd(0);
        cyc();
        cyc();
        checks++;
        if (bus.rd_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid got %0b want 0", bus.rd_valid);
        end
        checks++;
        if (bus.rd_data !== '0) begin
            errors++; $display("FAIL reset_data got %h want 0", bus.rd_data);
        end
        reset = 1'b0;
        idle();
        cyc();
    endtask

    task automatic test_accum();
        exp_t e;
        wr(0, 5, 1, 7);  cyc(); idle();
        wr(0, 5, 0, 3);  cyc(); idle();
        cyc(); cyc(); cyc();
        rd(5); sb.push_back('{0, 32'd10, "accum"});
        cyc(); idle();
        checks++;
        if (bus.rd_valid !== 1'b1) begin
            errors++; $display("FAIL accum_valid got %0b want 1", bus.rd_valid);
        end
        while (sb.size() > 0) begin
            e = sb.pop_front(); checks++;
            if (bus.rd_data[e.col*AC +: AC] !== e.val) begin
                errors++; $display("FAIL %s col %0d got %h want %h", e.name, e.col, bus.rd_data[e.col*AC +: AC], e.val);
            end
        end
    endtask

    task automatic test_all_cols();
        exp_t e;
        for (int c = 0; c < COLS; c++) wr(c, 1023, 1, c);
        cyc(); idle(); cyc();
        rd(1023);
        for (int c = 0; c < COLS; c++) sb.push_back('{c, c, "all_cols"});
        cyc(); idle();
        while (sb.size() > 0) begin
            e = sb.pop_front(); checks++;
            if (bus.rd_data[e.col*AC +: AC] !== e.val) begin
                errors++; $display("FAIL %s col %0d got %h want %h", e.name, e.col, bus.rd_data[e.col*AC +: AC], e.val);
            end
        end
    endtask

    task automatic test_wrap();
        exp_t e;
        wr(3, 0, 1, 32'h7FFF_FFFF); cyc(); idle();
        wr(3, 0, 0, 32'd1);         cyc(); idle();
        cyc();
        rd(0); sb.push_back('{3, 32'h8000_0000, "wrap"});
        cyc(); idle();
        while (sb.size() > 0) begin
            e = sb.pop_front(); checks++;
            if (bus.rd_data[e.col*AC +: AC] !== e.val) begin
                errors++; $display("FAIL %s col %0d got %h want %h", e.name, e.col, bus.rd_data[e.col*AC +: AC], e.val);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        wr(2, 9, 1, 1); cyc();
        for (int i = 0; i < 8; i++) begin
            wr(2, 9, 0, 1); cyc();
        end
        idle(); cyc();
        rd(9); sb.push_back('{2, 32'd9, "back_to_back"});
        cyc(); idle();
        while (sb.size() > 0) begin
            e = sb.pop_front(); checks++;
            if (bus.rd_data[e.col*AC +: AC] !== e.val) begin
                errors++; $display("FAIL %s col %0d got %h want %h", e.name, e.col, bus.rd_data[e.col*AC +: AC], e.val);
            end
        end
    endtask

    task automatic test_two_apart();
        exp_t e;
        wr(7, 7, 1, 100); cyc(); idle();
        cyc();
        wr(7, 7, 0, 1);   cyc(); idle();
        cyc();
        rd(7); sb.push_back('{7, 32'd101, "two_apart"});
        cyc(); idle();
        while (sb.size() > 0) begin
            e = sb.pop_front(); checks++;
            if (bus.rd_data[e.col*AC +: AC] !== e.val) begin
                errors++; $display("FAIL %s col %0d got %h want %h", e.name, e.col, bus.rd_data[e.col*AC +: AC], e.val);
            end
        end
    endtask

    task automatic test_wr_en_off();
        exp_t e;
        wr(4, 3, 1, 11); wr(6, 3, 1, 66); cyc(); idle();
        wr(4, 3, 1, 999); bus.wr_en[4] = 1'b0;
        wr(6, 3, 0, 1);
        cyc(); idle(); cyc();
        rd(3);
        sb.push_back('{4, 32'd11, "wr_en_off"});
        sb.push_back('{6, 32'd67, "col_indep"});
        cyc(); idle();
        while (sb.size() > 0) begin
            e = sb.pop_front(); checks++;
            if (bus.rd_data[e.col*AC +: AC] !== e.val) begin
                errors++; $display("FAIL %s col %0d got %h want %h", e.name, e.col, bus.rd_data[e.col*AC +: AC], e.val);
            end
        end
    endtask

    task automatic test_read_during_write();
        exp_t e;
        wr(5, 6, 1, 1); cyc(); idle();
        cyc();
        wr(5, 6, 1, 2); cyc(); idle();
        rd(6); sb.push_back('{5, 32'd1, "rd_during_wr"});
        cyc(); idle();
        while (sb.size() > 0) begin
            e = sb.pop_front(); checks++;
            if (bus.rd_data[e.col*AC +: AC] !== e.val) begin
                errors++; $display("FAIL %s col %0d got %h want %h", e.name, e.col, bus.rd_data[e.col*AC +: AC], e.val);
            end
        end
        rd(6); sb.push_back('{5, 32'd2, "rd_after_wr"});
        cyc(); idle();
        while (sb.size() > 0) begin
            e = sb.pop_front(); checks++;
            if (bus.rd_data[e.col*AC +: AC] !== e.val) begin
                errors++; $display("FAIL %s col %0d got %h want %h", e.name, e.col, bus.rd_data[e.col*AC +: AC], e.val);
            end
        end
    endtask

    task automatic test_reset_flush();
        exp_t e;
        wr(0, 4, 1, 20); cyc(); idle();
        cyc();
        wr(0, 4, 0, 5);  cyc(); idle();
        reset = 1'b1; rd(4);
        cyc();
        checks++;
        if (bus.rd_valid !== 1'b0) begin
            errors++; $display("FAIL flush_valid got %0b want 0", bus.rd_valid);
        end
        reset = 1'b0; idle();
        cyc();
        rd(4); sb.push_back('{0, 32'd20, "reset_flush"});
        cyc(); idle();
        while (sb.size() > 0) begin
            e = sb.pop_front(); checks++;
            if (bus.rd_data[e.col*AC +: AC] !== e.val) begin
                errors++; $display("FAIL %s col %0d got %h want %h", e.name, e.col, bus.rd_data[e.col*AC +: AC], e.val);
            end
        end
    endtask

    task automatic test_read_latency();
        exp_t e;
        wr(1, 2, 1, 50); cyc(); idle();
        rd(2); cyc();
        rd(2); sb.push_back('{1, 32'd50, "rd_latency"});
        cyc(); idle();
        checks++;
        if (bus.rd_valid !== 1'b1) begin
            errors++; $display("FAIL latency_valid got %0b want 1", bus.rd_valid);
        end
        while (sb.size() > 0) begin
            e = sb.pop_front(); checks++;
            if (bus.rd_data[e.col*AC +: AC] !== e.val) begin
                errors++; $display("FAIL %s col %0d got %h want %h", e.name, e.col, bus.rd_data[e.col*AC +: AC], e.val);
            end
        end
        wr(1, 2, 1, 77); cyc(); idle();
        cyc();
        checks++;
        if (bus.rd_valid !== 1'b0) begin
            errors++; $display("FAIL idle_valid got %0b want 0", bus.rd_valid);
        end
        checks++;
        if (bus.rd_data[1*AC +: AC] !== 32'd50) begin
            errors++; $display("FAIL hold_data got %h want %h", bus.rd_data[1*AC +: AC], 32'd50);
        end
    endtask

    initial begin
        bus.wr_en = '0;
        bus.wr_addr = '0;
        bus.wr_overwrite = '0;
        bus.wr_data = '0;
        bus.rd_en = 1'b0;
        bus.rd_addr = '0;
        test_reset();
        test_accum();
        test_all_cols();
        test_wrap();
        test_back_to_back();
        test_two_apart();
        test_wr_en_off();
        test_read_during_write();
        test_reset_flush();
        test_read_latency();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
